axis_stream_exerciser: RTL and testbench

Self-checking AXI-Stream source/sink pair that drives the 256-bit input of the stream-resizing cascade and consumes its 256-bit output. The source emits a deterministic counting pattern with pseudo-random tvalid throttling. The sink applies pseudo-random tready backpressure, checks every received word against the expected pattern, and reports error count, first failing index, timeout and overrun. It is the initiator/responder end for the cascade in hardware bring-up and in simulation.

---
 rtl/axis_stream_exerciser.sv | 152 +++++++++++++++
 tb/tb_axis_stream_exerciser.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_exerciser.sv
// AXI-Stream source/sink exerciser: emits a counting pattern with LFSR-throttled tvalid,
// and checks the returned stream under LFSR-throttled tready, with a watchdog.
module axis_stream_exerciser #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned TX_RATE = 15,
    parameter int unsigned RX_RATE = 15,
    parameter logic [15:0] TX_SEED = 16'hACE1,
    parameter logic [15:0] RX_SEED = 16'h1D0F,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [31:0]       words,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overrun,
    output logic [15:0]       err_cnt,
    output logic [31:0]       first_err_idx
);

    localparam int unsigned LANES   = DATA_W / 32;
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, next_state;
    logic [15:0] tx_lfsr, rx_lfsr;
    logic [31:0] words_r, tx_cnt, rx_cnt, wd, tx_cnt_eff;
    logic        tx_stale;
    logic        start_ok, tx_hs, rx_hs, rx_last, wd_expire;
    logic        tx_gate, rx_gate, tx_issue, rx_match;

    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] k);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < LANES; i++)
            w[32*i +: 32] = k * 32'(LANES) + 32'(i);
        return w;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tx_lfsr <= TX_SEED;
            rx_lfsr <= RX_SEED;
        end else begin
            tx_lfsr <= lfsr_step(tx_lfsr);
            rx_lfsr <= lfsr_step(rx_lfsr);
        end
    end

    assign tx_gate   = (TX_RATE == 15) || (tx_lfsr[3:0] <= 4'(TX_RATE));
    assign rx_gate   = (RX_RATE == 15) || (rx_lfsr[3:0] <= 4'(RX_RATE));
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign tx_hs     = m_tvalid && m_tready;
    assign rx_hs     = s_tvalid && s_tready;
    assign rx_last   = (rx_cnt == words_r - 32'd1);
    assign rx_match  = (s_tdata == pattern(rx_cnt));
    assign wd_expire = (state == RUN) && !rx_hs && (wd == WD_LAST);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = (words != '0) ? RUN : DONE;
            RUN:        if ((rx_hs && rx_last) || wd_expire) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // A word still pending from an aborted run is stale: it must finish its handshake
    // for protocol reasons but must not advance the new run's count.
    assign tx_cnt_eff = tx_cnt + {31'b0, tx_hs && !tx_stale};
    assign tx_issue   = (state == RUN) && (next_state == RUN) && tx_gate && (tx_cnt_eff < words_r);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            tx_cnt   <= '0;
            tx_stale <= 1'b0;
        end else begin
            if (start_ok)                tx_cnt <= '0;
            else if (tx_hs && !tx_stale) tx_cnt <= tx_cnt + 32'd1;

            if (start_ok)   tx_stale <= m_tvalid && !m_tready;
            else if (tx_hs) tx_stale <= 1'b0;

            if (!m_tvalid || m_tready) begin
                m_tvalid <= tx_issue;
                if (tx_issue) m_tdata <= pattern(tx_cnt_eff);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            words_r       <= '0;
            rx_cnt        <= '0;
            wd            <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            timeout       <= 1'b0;
            overrun       <= 1'b0;
            s_tready      <= 1'b0;
        end else begin
            if (start_ok) begin
                words_r       <= words;
                rx_cnt        <= '0;
                wd            <= '0;
                err_cnt       <= '0;
                first_err_idx <= '0;
                timeout       <= 1'b0;
                overrun       <= 1'b0;
            end else if (state == RUN) begin
                if (rx_hs) begin
                    rx_cnt <= rx_cnt + 32'd1;
                    wd     <= '0;
                    if (!rx_match) begin
                        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                        if (err_cnt == '0)       first_err_idx <= rx_cnt;
                    end
                end else begin
                    wd <= wd + 32'd1;
                end
                if (wd_expire) timeout <= 1'b1;
            end else if (state == DONE && rx_hs) begin
                overrun <= 1'b1;
            end
            // DONE keeps tready high so a stalled upstream can drain.
            s_tready <= (next_state == RUN) ? rx_gate : (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_axis_stream_exerciser.sv
// Directed bench: loopback, error injection, zero-length, watchdog, throttled FIFO path, mid-run reset.
module tb_axis_stream_exerciser;

    localparam int unsigned DW = 256;

    logic aclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int unsigned k);
        logic [DW-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < DW / 32; i++) w[32*i +: 32] = 32'(k * (DW / 32) + i);
        return w;
    endfunction

    // ---------------- instance A: loopback, rates 15 ----------------
    logic          a_start = 1'b0, flip_en = 1'b0;
    logic [31:0]   a_words = '0;
    logic [DW-1:0] a_m_tdata, a_s_tdata;
    logic          a_m_tvalid, a_s_tready, a_busy, a_done, a_timeout, a_overrun;
    logic [15:0]   a_err_cnt;
    logic [31:0]   a_first_err_idx;
    int            a_tx_idx;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n)                         a_tx_idx <= 0;
        else if (a_start)                   a_tx_idx <= 0;
        else if (a_m_tvalid && a_s_tready)  a_tx_idx <= a_tx_idx + 1;
    end

    always_comb begin
        a_s_tdata = a_m_tdata;
        if (flip_en && a_tx_idx == 5) a_s_tdata[0] = ~a_m_tdata[0];
    end

    axis_stream_exerciser #(.DATA_W(DW), .TX_RATE(15), .RX_RATE(15), .TIMEOUT(4096)) u_dut (
        .aclk(aclk), .aresetn(rst_n), .start(a_start), .words(a_words),
        .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_s_tready),
        .s_tdata(a_s_tdata), .s_tvalid(a_m_tvalid), .s_tready(a_s_tready),
        .busy(a_busy), .done(a_done), .timeout(a_timeout), .overrun(a_overrun),
        .err_cnt(a_err_cnt), .first_err_idx(a_first_err_idx)
    );

    // ---------------- instance B: throttled, through a 4-deep FIFO ----------------
    logic          b_start = 1'b0;
    logic [31:0]   b_words = '0;
    logic [DW-1:0] b_m_tdata, b_s_tdata;
    logic          b_m_tvalid, b_m_tready, b_s_tvalid, b_s_tready;
    logic          b_busy, b_done, b_timeout, b_overrun;
    logic [15:0]   b_err_cnt;
    logic [31:0]   b_first_err_idx;
    logic [DW-1:0] fifo [4];
    logic [1:0]    f_wr, f_rd;
    logic [2:0]    f_cnt;
    logic [7:0]    cyc;
    logic          push, pop;
    int            b_rx_words, b_bad, viol;
    logic          prev_v, prev_r, mon_en = 1'b0;
    logic [DW-1:0] prev_d;

    assign b_m_tready = (f_cnt != 3'd4) && (cyc[2:0] != 3'd5);
    assign b_s_tvalid = (f_cnt != 3'd0);
    assign b_s_tdata  = fifo[f_rd];
    assign push       = b_m_tvalid && b_m_tready;
    assign pop        = b_s_tvalid && b_s_tready;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            f_wr <= '0; f_rd <= '0; f_cnt <= '0; cyc <= '0; b_rx_words <= 0; b_bad <= 0;
        end else begin
            cyc <= cyc + 8'd1;
            if (push) begin fifo[f_wr] <= b_m_tdata; f_wr <= f_wr + 2'd1; end
            if (pop) begin
                f_rd <= f_rd + 2'd1;
                b_rx_words <= b_rx_words + 1;
                if (b_s_tdata !== exp_word(b_rx_words)) b_bad <= b_bad + 1;
            end
            f_cnt <= f_cnt + {2'b0, push} - {2'b0, pop};
        end
    end

    always_ff @(negedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            viol <= 0; prev_v <= 1'b0; prev_r <= 1'b0; prev_d <= '0;
        end else if (mon_en) begin
            if (prev_v && !prev_r && (!b_m_tvalid || b_m_tdata !== prev_d)) viol <= viol + 1;
            prev_v <= b_m_tvalid;
            prev_r <= b_m_tready;
            prev_d <= b_m_tdata;
        end
    end

    axis_stream_exerciser #(.DATA_W(DW), .TX_RATE(3), .RX_RATE(3), .TIMEOUT(4096)) u_thr (
        .aclk(aclk), .aresetn(rst_n), .start(b_start), .words(b_words),
        .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
        .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
        .busy(b_busy), .done(b_done), .timeout(b_timeout), .overrun(b_overrun),
        .err_cnt(b_err_cnt), .first_err_idx(b_first_err_idx)
    );

    // ---------------- instance C: watchdog, sink never valid ----------------
    logic          c_start = 1'b0;
    logic [31:0]   c_words = '0;
    logic [DW-1:0] c_m_tdata;
    logic          c_m_tvalid, c_s_tready, c_busy, c_done, c_timeout, c_overrun;
    logic [15:0]   c_err_cnt;
    logic [31:0]   c_first_err_idx;

    axis_stream_exerciser #(.DATA_W(DW), .TX_RATE(15), .RX_RATE(15), .TIMEOUT(64)) u_wd (
        .aclk(aclk), .aresetn(rst_n), .start(c_start), .words(c_words),
        .m_tdata(c_m_tdata), .m_tvalid(c_m_tvalid), .m_tready(1'b1),
        .s_tdata('0), .s_tvalid(1'b0), .s_tready(c_s_tready),
        .busy(c_busy), .done(c_done), .timeout(c_timeout), .overrun(c_overrun),
        .err_cnt(c_err_cnt), .first_err_idx(c_first_err_idx)
    );

    task automatic check_a_reset_outputs(input string pfx);
        check_eq({pfx, "_m_tvalid"}, a_m_tvalid, 0);
        check_eq({pfx, "_m_tdata"}, a_m_tdata, 0);
        check_eq({pfx, "_s_tready"}, a_s_tready, 0);
        check_eq({pfx, "_busy"}, a_busy, 0);
        check_eq({pfx, "_done"}, a_done, 0);
        check_eq({pfx, "_timeout"}, a_timeout, 0);
        check_eq({pfx, "_overrun"}, a_overrun, 0);
        check_eq({pfx, "_err_cnt"}, a_err_cnt, 0);
        check_eq({pfx, "_first_err_idx"}, a_first_err_idx, 0);
    endtask

    initial begin
        int done_at, hs_n, hs_first, hs_last;
        logic busy_seen, tv_seen;

        repeat (3) @(negedge aclk);
        check_a_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge aclk);

        // loopback, 16 words, one per cycle
        a_words = 16; a_start = 1'b1;
        @(negedge aclk); a_start = 1'b0;
        check_eq("lb_busy_after_start", a_busy, 1);
        check_eq("lb_tvalid_after_start", a_m_tvalid, 0);
        done_at = -1; hs_n = 0; hs_first = -1; hs_last = -1;
        for (int k = 1; k <= 40; k++) begin
            if (a_m_tvalid && a_s_tready) begin
                hs_n++;
                if (hs_first < 0) hs_first = k;
                hs_last = k;
            end
            @(negedge aclk);
            if (a_done && done_at < 0) done_at = k;
        end
        check_eq("lb_hs_count", hs_n, 16);
        check_eq("lb_hs_first_edge", hs_first, 2);
        check_eq("lb_hs_last_edge", hs_last, 17);
        check_eq("lb_done_latency", done_at, 17);
        check_eq("lb_err_cnt", a_err_cnt, 0);
        check_eq("lb_timeout", a_timeout, 0);
        check_eq("lb_overrun", a_overrun, 0);
        check_eq("lb_busy_end", a_busy, 0);
        check_eq("lb_s_tready_done", a_s_tready, 1);

        // loopback with bit 0 of word 5 corrupted
        flip_en = 1'b1;
        a_words = 16; a_start = 1'b1;
        @(negedge aclk); a_start = 1'b0;
        for (int k = 0; k < 60 && !a_done; k++) @(negedge aclk);
        flip_en = 1'b0;
        check_eq("flip_done", a_done, 1);
        check_eq("flip_err_cnt", a_err_cnt, 1);
        check_eq("flip_first_err_idx", a_first_err_idx, 5);
        check_eq("flip_overrun", a_overrun, 0);
        check_eq("flip_timeout", a_timeout, 0);

        // zero-length run
        a_words = 0; a_start = 1'b1;
        @(negedge aclk); a_start = 1'b0;
        check_eq("zero_done_one_edge", a_done, 1);
        check_eq("zero_err_cleared", a_err_cnt, 0);
        check_eq("zero_first_idx_cleared", a_first_err_idx, 0);
        busy_seen = a_busy; tv_seen = a_m_tvalid;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            busy_seen |= a_busy;
            tv_seen |= a_m_tvalid;
        end
        check_eq("zero_busy_never", busy_seen, 0);
        check_eq("zero_tvalid_never", tv_seen, 0);

        // watchdog, TIMEOUT 64
        c_words = 8; c_start = 1'b1;
        @(negedge aclk); c_start = 1'b0;
        done_at = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge aclk);
            if (c_done && done_at < 0) done_at = k;
        end
        check_eq("wd_done_latency", done_at, 64);
        check_eq("wd_timeout", c_timeout, 1);
        check_eq("wd_err_cnt", c_err_cnt, 0);
        check_eq("wd_first_idx", c_first_err_idx, 0);
        check_eq("wd_overrun", c_overrun, 0);
        check_eq("wd_busy", c_busy, 0);
        check_eq("wd_s_tready_done", c_s_tready, 1);
        check_eq("wd_tvalid_end", c_m_tvalid, 0);
        check_eq("wd_last_tdata", c_m_tdata, exp_word(7));

        // throttled run through FIFO, 1000 words
        mon_en = 1'b1;
        b_words = 1000; b_start = 1'b1;
        @(negedge aclk); b_start = 1'b0;
        for (int k = 0; k < 20000 && !b_done; k++) @(negedge aclk);
        mon_en = 1'b0;
        check_eq("thr_done", b_done, 1);
        check_eq("thr_err_cnt", b_err_cnt, 0);
        check_eq("thr_first_idx", b_first_err_idx, 0);
        check_eq("thr_timeout", b_timeout, 0);
        check_eq("thr_overrun", b_overrun, 0);
        check_eq("thr_busy", b_busy, 0);
        check_eq("thr_rx_words", b_rx_words, 1000);
        check_eq("thr_bench_data_bad", b_bad, 0);
        check_eq("thr_hold_violations", viol, 0);

        // reset mid-run, then a fresh run
        a_words = 1000; a_start = 1'b1;
        @(negedge aclk); a_start = 1'b0;
        for (int k = 0; k < 2000 && a_tx_idx < 300; k++) @(negedge aclk);
        check_eq("rst_reached_word300", a_tx_idx >= 300, 1);
        check_eq("rst_busy_before", a_busy, 1);
        rst_n = 1'b0;
        #1;
        check_a_reset_outputs("midrst");
        @(negedge aclk); rst_n = 1'b1;
        @(negedge aclk);
        a_words = 1000; a_start = 1'b1;
        @(negedge aclk); a_start = 1'b0;
        for (int k = 0; k < 3000 && !a_done; k++) @(negedge aclk);
        check_eq("rerun_done", a_done, 1);
        check_eq("rerun_err_cnt", a_err_cnt, 0);
        check_eq("rerun_timeout", a_timeout, 0);
        check_eq("rerun_overrun", a_overrun, 0);
        check_eq("rerun_tx_words", a_tx_idx, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
